sc_score_tracker: RTL and testbench

//   Downstream consumer of the match serializer. Takes one serialized hit per

---
 rtl/sc_score_pkg.sv | 43 ++++
 rtl/sc_hit_classifier.sv | 51 +++++
 rtl/sc_score_tracker.sv | 129 ++++++++++++
 tb/tb_sc_score_tracker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_score_pkg.sv
// Shared types and widths for the score tracker.
// Optional feature macro: SC_STAR_POWER_EN (star-power doubling).
package sc_score_pkg;

    localparam int unsigned COMBO_W = 10;
    localparam int unsigned DT_W    = 16;
    localparam int unsigned PTS_W   = 16;

`ifdef SC_STAR_POWER_EN
    // The doubled ceiling (2*MAX_MULT = 8) needs a fourth bit.
    localparam int unsigned MULT_W  = 4;
`else
    localparam int unsigned MULT_W  = 3;
`endif

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'd0,
        GRADE_GOOD    = 2'd1,
        GRADE_PERFECT = 2'd2
    } grade_e;

    // Stage-1 result handed to the accumulator.
    typedef struct packed {
        logic   hit;
        logic   miss;
        grade_e grade;
    } stage1_t;

    // Base multiplier earned by a given combo count.
    function automatic logic [MULT_W-1:0] mult_for_combo(
        input logic [COMBO_W-1:0] c,
        input int unsigned        step,
        input int unsigned        max_mult
    );
        int unsigned m;
        m = 32'd1 + (32'(c) / step);
        if (m > max_mult) begin
            m = max_mult;
        end
        return MULT_W'(m);
    endfunction

endpackage

// File: rtl/sc_hit_classifier.sv
// Stage 1: absolute timing error, saturation, window compare, registered grade.
// Optional feature macro: SC_STAR_POWER_EN (not used in this stage).
module sc_hit_classifier
    import sc_score_pkg::*;
#(
    parameter int unsigned PERFECT_WIN = 2,
    parameter int unsigned GOOD_WIN    = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            match_en,
    input  logic [DT_W-1:0] match_dt,
    input  logic            miss_en,
    output stage1_t         result
);

    localparam logic [DT_W-1:0] DT_MIN = {1'b1, {(DT_W-1){1'b0}}};
    localparam logic [DT_W-1:0] DT_MAX = {1'b0, {(DT_W-1){1'b1}}};

    logic [DT_W-1:0] mag_c;
    grade_e          grade_c;

    // Magnitude of the signed error; the most negative value clamps to max positive.
    always_comb begin
        mag_c   = match_dt[DT_W-1] ? (~match_dt + DT_W'(1)) : match_dt;
        if (match_dt == DT_MIN) begin
            mag_c = DT_MAX;
        end
        grade_c = GRADE_MISS;
        if (mag_c <= DT_W'(PERFECT_WIN)) begin
            grade_c = GRADE_PERFECT;
        end else if (mag_c <= DT_W'(GOOD_WIN)) begin
            grade_c = GRADE_GOOD;
        end
    end

    // Stage-1 register; clear flushes anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '{hit: 1'b0, miss: 1'b0, grade: GRADE_MISS};
        end else if (clear) begin
            result <= '{hit: 1'b0, miss: 1'b0, grade: GRADE_MISS};
        end else begin
            result.hit   <= match_en;
            result.miss  <= miss_en;
            result.grade <= match_en ? grade_c : GRADE_MISS;
        end
    end

endmodule

// File: rtl/sc_score_tracker.sv
// Score tracker top: stage-2 accumulation of score, combo and multiplier.
// Optional feature macro: SC_STAR_POWER_EN adds star_active, doubling the multiplier.
module sc_score_tracker
    import sc_score_pkg::*;
#(
    parameter int unsigned PERFECT_WIN = 2,
    parameter int unsigned GOOD_WIN    = 6,
    parameter int unsigned PERFECT_PTS = 100,
    parameter int unsigned GOOD_PTS    = 50,
    parameter int unsigned COMBO_STEP  = 10,
    parameter int unsigned MAX_MULT    = 4,
    parameter int unsigned SCORE_W     = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               match_en,
    input  logic [DT_W-1:0]    match_dt,
    input  logic               miss_en,
`ifdef SC_STAR_POWER_EN
    input  logic               star_active,
`endif
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [MULT_W-1:0]  multiplier,
    output logic               grade_valid,
    output logic [1:0]         grade
);

    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    stage1_t s1;

    logic [MULT_W-1:0]  base_mult;
    logic [MULT_W-1:0]  base_mult_n;
    logic [MULT_W-1:0]  eff_mult_c;
    logic [MULT_W-1:0]  mult_out_n;
    logic [PTS_W-1:0]   pts_c;
    logic [SCORE_W:0]   score_sum_c;
    logic [COMBO_W-1:0] combo_inc_c;
    logic [SCORE_W-1:0] score_n;
    logic [COMBO_W-1:0] combo_n;
    logic               grade_valid_n;
    logic [1:0]         grade_n;
    logic               good_hit_c;
    logic               break_c;
    logic               star_c;

    sc_hit_classifier #(
        .PERFECT_WIN (PERFECT_WIN),
        .GOOD_WIN    (GOOD_WIN)
    ) u_classifier (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .match_en (match_en),
        .match_dt (match_dt),
        .miss_en  (miss_en),
        .result   (s1)
    );

`ifdef SC_STAR_POWER_EN
    assign star_c = star_active;
`else
    assign star_c = 1'b0;
`endif

    // Stage-2 next state: credit the hit at the old multiplier, then apply any combo break.
    always_comb begin
        score_n       = score;
        combo_n       = combo;
        base_mult_n   = base_mult;
        grade_valid_n = 1'b0;
        grade_n       = grade;

        eff_mult_c  = star_c ? MULT_W'(base_mult << 1) : base_mult;
        pts_c       = (s1.grade == GRADE_PERFECT) ? PTS_W'(PERFECT_PTS) : PTS_W'(GOOD_PTS);
        pts_c       = pts_c * PTS_W'(eff_mult_c);
        score_sum_c = {1'b0, score} + (SCORE_W+1)'(pts_c);
        combo_inc_c = (combo == COMBO_MAX) ? combo : combo + COMBO_W'(1);

        good_hit_c  = s1.hit && (s1.grade != GRADE_MISS);
        break_c     = s1.miss || (s1.hit && (s1.grade == GRADE_MISS));

        if (good_hit_c) begin
            score_n     = score_sum_c[SCORE_W] ? SCORE_MAX : score_sum_c[SCORE_W-1:0];
            combo_n     = combo_inc_c;
            base_mult_n = mult_for_combo(combo_inc_c, COMBO_STEP, MAX_MULT);
        end
        if (break_c) begin
            combo_n     = '0;
            base_mult_n = MULT_W'(1);
        end
        if (s1.hit || s1.miss) begin
            grade_valid_n = 1'b1;
            grade_n       = s1.miss ? 2'(GRADE_MISS) : 2'(s1.grade);
        end

        mult_out_n = star_c ? MULT_W'(base_mult_n << 1) : base_mult_n;
    end

    // Stage-2 registers; clear behaves like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score       <= '0;
            combo       <= '0;
            base_mult   <= MULT_W'(1);
            multiplier  <= MULT_W'(1);
            grade_valid <= 1'b0;
            grade       <= 2'(GRADE_MISS);
        end else if (clear) begin
            score       <= '0;
            combo       <= '0;
            base_mult   <= MULT_W'(1);
            multiplier  <= MULT_W'(1);
            grade_valid <= 1'b0;
            grade       <= 2'(GRADE_MISS);
        end else begin
            score       <= score_n;
            combo       <= combo_n;
            base_mult   <= base_mult_n;
            multiplier  <= mult_out_n;
            grade_valid <= grade_valid_n;
            grade       <= grade_n;
        end
    end

endmodule

// File: tb/tb_sc_score_tracker.sv
// Scoreboard bench for sc_score_tracker; honours SC_STAR_POWER_EN when defined.
module tb_sc_score_tracker;
    import sc_score_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               clear;
    logic               match_en;
    logic [DT_W-1:0]    match_dt;
    logic               miss_en;
    logic               star_active;
    logic [23:0]        score;
    logic [COMBO_W-1:0] combo;
    logic [MULT_W-1:0]  multiplier;
    logic               grade_valid;
    logic [1:0]         grade;

    sc_score_tracker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .match_en    (match_en),
        .match_dt    (match_dt),
        .miss_en     (miss_en),
`ifdef SC_STAR_POWER_EN
        .star_active (star_active),
`endif
        .score       (score),
        .combo       (combo),
        .multiplier  (multiplier),
        .grade_valid (grade_valid),
        .grade       (grade)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int     cyc;
        int     grade;
        longint score;
        int     combo;
        int     mult;
    } exp_t;

    exp_t q[$];

    // Reference model state
    longint m_score;
    int     m_combo;

    function automatic int m_mult(input int c);
        int m;
        m = 1 + c / 10;
        return (m > 4) ? 4 : m;
    endfunction

    task automatic model_reset();
        m_score = 0;
        m_combo = 0;
        q.delete();
    endtask

    task automatic model_event(input logic hit, input logic [15:0] dt, input logic miss);
        int   d, ad, g, sf;
        exp_t e;
        d  = int'($signed(dt));
        ad = (d < 0) ? -d : d;
        if (ad > 32767) ad = 32767;
        g  = !hit ? 0 : (ad <= 2) ? 2 : (ad <= 6) ? 1 : 0;
        sf = star_active ? 2 : 1;
        if (hit && g != 0) begin
            m_score += longint'(((g == 2) ? 100 : 50) * m_mult(m_combo) * sf);
            if (m_score > 64'd16777215) m_score = 16777215;
            if (m_combo < 1023) m_combo++;
        end
        if (miss || (hit && g == 0)) m_combo = 0;
        e.cyc   = cyc + 2;
        e.grade = miss ? 0 : g;
        e.score = m_score;
        e.combo = m_combo;
        e.mult  = m_mult(m_combo) * sf;
        q.push_back(e);
    endtask

    // Drive one cycle of stimulus; expectation is queued at drive time.
    task automatic step(input logic hit, input logic [15:0] dt, input logic miss);
        match_en = hit;
        match_dt = dt;
        miss_en  = miss;
        if (hit || miss) model_event(hit, dt, miss);
        @(posedge clk);
        #1;
        match_en = 1'b0;
        miss_en  = 1'b0;
        match_dt = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 10) begin
            idle(1);
            k++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Output monitor: every grade_valid must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (grade_valid) begin
                if (q.size() == 0) begin
                    check("spurious_grade_valid", grade_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc, e.cyc);
                    check("grade", grade, e.grade);
                    check("score", score, e.score);
                    check("combo", combo, e.combo);
                    check("multiplier", multiplier, e.mult);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        match_en    = 1'b0;
        match_dt    = '0;
        miss_en     = 1'b0;
        star_active = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_score", score, 0);
        check("rst_combo", combo, 0);
        check("rst_mult", multiplier, 1);
        check("rst_gv", grade_valid, 0);
        check("rst_grade", grade, 0);
        rst_n = 1'b1;
        idle(2);

        // Ten perfect hits reach the first multiplier step
        repeat (10) step(1'b1, 16'd0, 1'b0);
        drain();
        check("t1_score", score, 1000);
        check("t1_combo", combo, 10);
        check("t1_mult", multiplier, 2);
        step(1'b1, 16'hFFFF, 1'b0);
        drain();
        check("t1_score11", score, 1200);

        // GOOD window edge and first out-of-window value
        do_clear();
        step(1'b1, 16'd5, 1'b0);
        drain();
        check("t2_score_good", score, 50);
        check("t2_grade_good", grade, 1);
        step(1'b1, 16'd7, 1'b0);
        drain();
        check("t2_score_miss", score, 50);
        check("t2_combo_miss", combo, 0);
        check("t2_grade_miss", grade, 0);
        step(1'b1, 16'hFFFA, 1'b0);
        step(1'b1, 16'd2, 1'b0);
        step(1'b1, 16'd3, 1'b0);
        drain();
        check("t2_mixed_score", score, 250);

        // Back-to-back perfect hits up to the multiplier ceiling
        do_clear();
        repeat (40) step(1'b1, 16'd0, 1'b0);
        drain();
        check("t3_score", score, 10000);
        check("t3_mult", multiplier, 4);
        check("t3_combo", combo, 40);

        // Most negative dt, then a miss sharing the slot with a hit
        do_clear();
        step(1'b1, 16'h8000, 1'b0);
        drain();
        check("t4_min_dt_grade", grade, 0);
        check("t4_min_dt_score", score, 0);
        repeat (15) step(1'b1, 16'd1, 1'b0);
        drain();
        check("t4_pre_combo", combo, 15);
        check("t4_pre_score", score, 2000);
        step(1'b1, 16'd0, 1'b1);
        drain();
        check("t4_score", score, 2200);
        check("t4_combo", combo, 0);
        check("t4_mult", multiplier, 1);
        check("t4_grade", grade, 0);
        repeat (3) step(1'b1, 16'd0, 1'b0);
        step(1'b0, 16'd0, 1'b1);
        drain();
        check("t4_lone_miss_combo", combo, 0);
        check("t4_lone_miss_score", score, 2500);

`ifdef SC_STAR_POWER_EN
        // Star power doubles points and the visible multiplier
        star_active = 1'b1;
        do_clear();
        idle(2);
        step(1'b1, 16'd0, 1'b0);
        drain();
        check("t6_star_score", score, 200);
        check("t6_star_mult", multiplier, 2);
        star_active = 1'b0;
        idle(2);
        check("t6_star_off_mult", multiplier, 1);
`endif

        // Long run drives score and combo into saturation
        do_clear();
        repeat (42000) step(1'b1, 16'd0, 1'b0);
        drain();
        check("t5_score_sat", score, 16777215);
        check("t5_combo_sat", combo, 1023);
        check("t5_mult_sat", multiplier, 4);

        // Asynchronous reset with a hit in flight
        step(1'b1, 16'd0, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_arst_score", score, 0);
        check("t5_arst_combo", combo, 0);
        check("t5_arst_mult", multiplier, 1);
        check("t5_arst_gv", grade_valid, 0);
        @(posedge clk);
        #1;
        check("t5_arst_gv_edge", grade_valid, 0);
        check("t5_arst_grade", grade, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        check("t5_post_rst_score", score, 0);
        step(1'b1, 16'd0, 1'b0);
        drain();
        check("t5_recover_score", score, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
